// File: rtl/seg_scan_controller.sv
// Multiplexed hex display scanner: drives one shared nibble decoder and DIGITS common-anode digits.
// New score values wait in a staging register and are only applied at a frame boundary.
module seg_scan_controller #(
  parameter int DIGITS       = 8,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 4,
  parameter int BLANK_LZ     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     point_in,
  input  logic                  value_load,
  input  logic                  enable,
  output logic [3:0]            hex_out,
  input  logic [7:0]            seg_from_dec,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CntLast  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GuardEnd = CW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IdxLast  = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadowVal_q, shadowVal_d;
  logic [DIGITS-1:0]     shadowPt_q, shadowPt_d;
  logic [4*DIGITS-1:0]   stageVal_q, stageVal_d;
  logic [DIGITS-1:0]     stagePt_q, stagePt_d;
  logic                  pending_q, pending_d;
  logic                  frameDone_q, frameDone_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic                  cntWrap;
  logic                  boundary;
  logic                  upperZero;
  logic                  blankDigit;
  logic                  litDigit;
  logic                  curPoint;
  logic [DIGITS-1:0]     anOneHot;
  logic                  unusedDecBit;

  // The decoder always drives bit 7 high; the point comes from our own register instead.
  assign unusedDecBit = seg_from_dec[7];

  assign cntWrap  = (cnt_q == CntLast);
  assign boundary = cntWrap && (idx_q == IdxLast);
  assign hex_out  = shadowVal_q[{idx_q, 2'b00} +: 4];
  assign curPoint = shadowPt_q[idx_q];

  always_comb begin
    cnt_d = cntWrap ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (cntWrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IW'(1);
    end

    shadowVal_d = shadowVal_q;
    shadowPt_d  = shadowPt_q;
    stageVal_d  = stageVal_q;
    stagePt_d   = stagePt_q;
    pending_d   = pending_q;
    frameDone_d = boundary && pending_q;
    if (boundary && pending_q) begin
      shadowVal_d = stageVal_q;
      shadowPt_d  = stagePt_q;
      pending_d   = 1'b0;
    end
    // A load on the boundary cycle lands in staging after the old staging has moved on.
    if (value_load) begin
      stageVal_d = value_in;
      stagePt_d  = point_in;
      pending_d  = 1'b1;
    end
  end

  always_comb begin
    upperZero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(idx_q)) && (shadowVal_q[4*i +: 4] != 4'd0)) begin
        upperZero = 1'b0;
      end
    end
    blankDigit = (BLANK_LZ != 0) && (idx_q != '0) && upperZero && !curPoint;
    litDigit   = enable && (cnt_q >= GuardEnd) && !blankDigit;

    anOneHot        = '0;
    anOneHot[idx_q] = 1'b1;
    an_d  = litDigit ? ~anOneHot : '1;
    seg_d = litDigit ? {~curPoint, seg_from_dec[6:0]} : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadowVal_q <= '0;
      shadowPt_q  <= '0;
      stageVal_q  <= '0;
      stagePt_q   <= '0;
      pending_q   <= 1'b0;
      frameDone_q <= 1'b0;
      an_q        <= '1;
      seg_q       <= 8'hFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadowVal_q <= shadowVal_d;
      shadowPt_q  <= shadowPt_d;
      stageVal_q  <= stageVal_d;
      stagePt_q   <= stagePt_d;
      pending_q   <= pending_d;
      frameDone_q <= frameDone_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign pending    = pending_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with 8 digits, 8-cycle slots and 2 guard cycles.
// A second instance with leading-zero blanking off stays at value 0 for the whole run.
module tb_seg_scan_controller;

  logic        clk;
  logic        rst;
  logic [31:0] value_in;
  logic [7:0]  point_in;
  logic        value_load;
  logic        enable;
  logic [3:0]  hex_out;
  logic [7:0]  seg_from_dec;
  logic [7:0]  seg_out;
  logic [7:0]  an_out;
  logic        pending;
  logic        frame_done;

  logic [31:0] nolzValue;
  logic [7:0]  nolzPoint;
  logic        nolzLoad;
  logic        nolzEnable;
  logic [3:0]  nolzHex;
  logic [7:0]  nolzSegDec;
  logic [7:0]  nolzSeg;
  logic [7:0]  nolzAn;
  logic        nolzPending;
  logic        nolzDone;

  int compared;
  int mismatched;

  logic [31:0] loadValQ[$];
  logic [7:0]  loadPtQ[$];

  function automatic logic [7:0] dec7(input logic [3:0] h);
    case (h)
      4'h0: dec7 = 8'hC0;  4'h1: dec7 = 8'hF9;  4'h2: dec7 = 8'hA4;  4'h3: dec7 = 8'hB0;
      4'h4: dec7 = 8'h99;  4'h5: dec7 = 8'h92;  4'h6: dec7 = 8'h82;  4'h7: dec7 = 8'hF8;
      4'h8: dec7 = 8'h80;  4'h9: dec7 = 8'h90;  4'hA: dec7 = 8'h88;  4'hB: dec7 = 8'h83;
      4'hC: dec7 = 8'hC6;  4'hD: dec7 = 8'hA1;  4'hE: dec7 = 8'h86;  default: dec7 = 8'h8E;
    endcase
  endfunction

  assign seg_from_dec = dec7(hex_out);
  assign nolzSegDec   = dec7(nolzHex);

  seg_scan_controller #(
    .DIGITS(8), .SLOT_CYCLES(8), .GUARD_CYCLES(2), .BLANK_LZ(1)
  ) u_dut (
    .clk(clk), .rst(rst), .value_in(value_in), .point_in(point_in),
    .value_load(value_load), .enable(enable), .hex_out(hex_out),
    .seg_from_dec(seg_from_dec), .seg_out(seg_out), .an_out(an_out),
    .pending(pending), .frame_done(frame_done)
  );

  seg_scan_controller #(
    .DIGITS(8), .SLOT_CYCLES(8), .GUARD_CYCLES(2), .BLANK_LZ(0)
  ) u_dut_nolz (
    .clk(clk), .rst(rst), .value_in(nolzValue), .point_in(nolzPoint),
    .value_load(nolzLoad), .enable(nolzEnable), .hex_out(nolzHex),
    .seg_from_dec(nolzSegDec), .seg_out(nolzSeg), .an_out(nolzAn),
    .pending(nolzPending), .frame_done(nolzDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic loadNow);
    value_load = loadNow;
    if (loadNow) begin
      value_in = loadValQ.pop_front();
      point_in = loadPtQ.pop_front();
    end
  endtask

  // Table byte i is the expected lit an/seg for slot i; outputs lag state by one cycle,
  // so iteration j observes slot j/8, count j%8, and iteration 63 observes the boundary cycle.
  task automatic checkFrame(input string tag, input logic [63:0] anTab, input logic [63:0] segTab,
                            input logic expDone, input logic [63:0] loadMask);
    logic [7:0] expAn;
    logic [7:0] expSeg;
    logic [7:0] oneHot;
    for (int j = 0; j < 64; j++) begin
      expAn  = (j % 8 < 2) ? 8'hFF : anTab[(j/8)*8 +: 8];
      expSeg = (j % 8 < 2) ? 8'hFF : segTab[(j/8)*8 +: 8];
      checkOutput({tag, "_an"}, an_out, expAn);
      checkOutput({tag, "_seg"}, seg_out, expSeg);
      checkOutput({tag, "_done"}, {7'd0, frame_done}, {7'd0, (j == 63) ? expDone : 1'b0});
      oneHot = 8'h01 << (j / 8);
      checkOutput({tag, "_nolz_an"}, nolzAn, (j % 8 < 2) ? 8'hFF : ~oneHot);
      checkOutput({tag, "_nolz_seg"}, nolzSeg, (j % 8 < 2) ? 8'hFF : 8'hC0);
      applyStimulus(loadMask[j]);
      tick();
    end
    value_load = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_an"}, an_out, 8'hFF);
    checkOutput({tag, "_seg"}, seg_out, 8'hFF);
    checkOutput({tag, "_hex"}, {4'd0, hex_out}, 8'h00);
    checkOutput({tag, "_pending"}, {7'd0, pending}, 8'h00);
    checkOutput({tag, "_done"}, {7'd0, frame_done}, 8'h00);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    value_in   = '0;
    point_in   = '0;
    value_load = 1'b0;
    enable     = 1'b1;
    nolzValue  = '0;
    nolzPoint  = '0;
    nolzLoad   = 1'b0;
    nolzEnable = 1'b1;

    tick(); tick(); tick();
    checkReset("reset");
    rst = 1'b0;
    tick();

    // 0000_1234 loaded in cycle 3; zero shadow shows only digit 0 this frame.
    loadValQ.push_back(32'h0000_1234); loadPtQ.push_back(8'h00);
    checkFrame("f1_zero", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 64'h4);
    checkOutput("f1_pending_clear", {7'd0, pending}, 8'h00);
    checkOutput("f2_hex_digit0", {4'd0, hex_out}, 8'h04);

    checkFrame("f2_1234", 64'hFFFF_FFFF_F7FB_FDFE, 64'hFFFF_FFFF_F9A4_B099, 1'b0, 64'h0);

    loadValQ.push_back(32'h8765_4321); loadPtQ.push_back(8'h00);
    checkFrame("f3_1234", 64'hFFFF_FFFF_F7FB_FDFE, 64'hFFFF_FFFF_F9A4_B099, 1'b1, 64'h1);
    checkFrame("f4_all", 64'h7FBF_DFEF_F7FB_FDFE, 64'h80F8_8292_99B0_A4F9, 1'b0, 64'h0);

    // 11 then 22 inside the frame, 33 on the boundary cycle itself.
    loadValQ.push_back(32'h11); loadPtQ.push_back(8'h00);
    loadValQ.push_back(32'h22); loadPtQ.push_back(8'h00);
    loadValQ.push_back(32'h33); loadPtQ.push_back(8'h00);
    checkFrame("f5_all", 64'h7FBF_DFEF_F7FB_FDFE, 64'h80F8_8292_99B0_A4F9, 1'b1,
               (64'h1 << 5) | (64'h1 << 20) | (64'h1 << 62));
    checkOutput("f5_pending_kept", {7'd0, pending}, 8'h01);
    checkFrame("f6_22", 64'hFFFF_FFFF_FFFF_FDFE, 64'hFFFF_FFFF_FFFF_A4A4, 1'b1, 64'h0);
    checkOutput("f6_pending_clear", {7'd0, pending}, 8'h00);

    loadValQ.push_back(32'h0000_0005); loadPtQ.push_back(8'h04);
    checkFrame("f7_33", 64'hFFFF_FFFF_FFFF_FDFE, 64'hFFFF_FFFF_FFFF_B0B0, 1'b1, 64'h1 << 10);
    checkFrame("f8_point", 64'hFFFF_FFFF_FFFB_FFFE, 64'hFFFF_FFFF_FF40_FF92, 1'b0, 64'h0);

    // Dark for 20 cycles while the scan keeps moving, then a reset in the middle of slot 3.
    checkOutput("dark_hex_digit0", {4'd0, hex_out}, 8'h05);
    for (int j = 0; j < 28; j++) begin
      if (j >= 1 && j <= 20) begin
        checkOutput("dark_an", an_out, 8'hFF);
        checkOutput("dark_seg", seg_out, 8'hFF);
        checkOutput("dark_done", {7'd0, frame_done}, 8'h00);
      end
      if (j == 21 || j == 22) begin
        checkOutput("relit_an", an_out, 8'hFB);
        checkOutput("relit_seg", seg_out, 8'h40);
      end
      if (j == 23) checkOutput("dark_load_pending", {7'd0, pending}, 8'h01);
      if (j == 0) enable = 1'b0;
      if (j == 20) enable = 1'b1;
      if (j == 22) begin
        value_in   = 32'h9;
        point_in   = 8'h00;
        value_load = 1'b1;
      end else begin
        value_load = 1'b0;
      end
      if (j == 27) rst = 1'b1;
      tick();
    end
    checkReset("midslot_reset");
    rst = 1'b0;
    tick();

    checkFrame("f9_after_reset", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
